// File: rtl/div1_sched.sv
// Round-robin scheduler that shares one divide-by-(1+x) unit among NREQ requesters.
// Each job restarts the divider, waits for done (or times out) and returns a tagged result.
module div1_sched #(
  parameter int N       = 4480,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = N / 32 + 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_data,
  output logic              rsp_err,
  output logic              div_rst,
  output logic [N-1:0]      div_in,
  input  logic [N-1:0]      div_out,
  input  logic              div_done
);

  localparam int CW = $clog2(TIMEOUT + 2);

  if ((N % 32) != 0) begin : g_chk_n
    $error("div1_sched: N must be a multiple of 32");
  end
  if ((NREQ < 2) || (NREQ > 8)) begin : g_chk_nreq
    $error("div1_sched: NREQ must be in 2..8");
  end
  if (IDW < $clog2(NREQ)) begin : g_chk_idw
    $error("div1_sched: IDW too narrow for NREQ");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t         state_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] id_q;
  logic [IDW-1:0] rsp_id_q;
  logic [N-1:0]   op_q;
  logic [N-1:0]   rsp_data_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic           rsp_valid_q;
  logic           rsp_err_q;

  logic           hi_found_d;
  logic           lo_found_d;
  logic           hi_hit_d;
  logic           lo_hit_d;
  logic [IDW-1:0] hi_idx_d;
  logic [IDW-1:0] lo_idx_d;
  logic [IDW-1:0] win_d;
  logic [IDW-1:0] ptr_d;
  logic [N-1:0]   op_d;
  logic [NREQ-1:0] gnt_d;

  // Round-robin pick: lowest requester at or above ptr_q, else lowest below it (wrap).
  always_comb begin
    hi_found_d = 1'b0;
    lo_found_d = 1'b0;
    hi_hit_d   = 1'b0;
    lo_hit_d   = 1'b0;
    hi_idx_d   = '0;
    lo_idx_d   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      hi_hit_d   = req[k] && (IDW'(k) >= ptr_q);
      lo_hit_d   = req[k] && (IDW'(k) < ptr_q);
      hi_found_d = hi_found_d | hi_hit_d;
      lo_found_d = lo_found_d | lo_hit_d;
      hi_idx_d   = hi_hit_d ? IDW'(k) : hi_idx_d;
      lo_idx_d   = lo_hit_d ? IDW'(k) : lo_idx_d;
    end
    win_d = hi_found_d ? hi_idx_d : lo_idx_d;
    ptr_d = (win_d == IDW'(NREQ - 1)) ? '0 : (win_d + IDW'(1));
  end

  // Decode the winner into a one-hot grant and select its operand slice.
  always_comb begin
    gnt_d = '0;
    op_d  = op_q;
    for (int k = 0; k < NREQ; k++) begin
      gnt_d[k] = (hi_found_d | lo_found_d) && (win_d == IDW'(k));
      op_d     = gnt_d[k] ? req_data[k*N +: N] : op_d;
    end
  end

  // Grants are only offered from a settled IDLE state and never during reset.
  always_comb begin
    if ((state_q == S_IDLE) && !rst) begin
      gnt = gnt_d;
    end else begin
      gnt = '0;
    end
  end

  // Job FSM: capture on grant, restart divider, wait for done or timeout, respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|gnt_d) begin
            op_q    <= op_d;
            id_q    <= win_d;
            ptr_q   <= ptr_d;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          cnt_q   <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          // A done flag seen here belongs to this job: LOAD has just cleared the divider.
          if (div_done) begin
            rsp_data_q  <= div_out;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            state_q     <= S_RESP;
          end else if (cnt_q == CW'(TIMEOUT)) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RESP: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_id_q    <= '0;
          rsp_data_q  <= '0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign div_in    = op_q;
  assign div_rst   = rst | (state_q == S_LOAD);

endmodule

// File: doc/div1_sched.md
# div1_sched

Round-robin scheduler that shares one divide-by-(1+x) unit (`divide_1`, 32 coefficients/cycle) among up to NREQ interpolation-stage requesters in the Toom-K datapath. It grants one requester at a time and captures that requester's operand. It restarts the divider by pulsing the divider's synchronous reset, then waits for the divider's done flag. It returns the quotient tagged with the requester index, and flags an error if the divider hangs.

## Interface
- N, 4480, polynomial width in bits; must be a multiple of 32 (elaboration-time `$error` otherwise)
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of rsp_id; must be ≥ clog2(NREQ)
- TIMEOUT, N/32+8, RUN-state cycle limit before abort
- clk  in  1  clock; one clock domain. Reset is synchronous and active-high (`rst`).
- rst  in  1  synchronous active-high reset
- req  in  NREQ  request vector; req[k] held high with operand valid until gnt[k]
- req_data  in  NREQ*N  flattened operands; slice k is [k*N +: N]
- gnt  out  NREQ  one-hot one-cycle grant pulse; operand k captured that cycle
- busy  out  1  high in every state except IDLE
- rsp_valid  out  1  one-cycle result strobe; no backpressure
- rsp_id  out  IDW  index of requester the result belongs to
- rsp_data  out  N  quotient; zero when rsp_err=1
- rsp_err  out  1  valid only with rsp_valid; 1 means timeout abort
- div_rst  out  1  to divider rst
- div_in  out  N  to divider in; held stable from LOAD through RUN
- div_out  in  N  from divider out
- div_done  in  1  from divider done

## Operation
- States: IDLE, LOAD, RUN, RESP.
- IDLE: if any req bit is set, pick a winner by round-robin. The search starts at index ptr and wraps modulo NREQ. Then: gnt[winner]=1; op_reg<=req_data slice; id_reg<=winner; ptr<=(winner+1) mod NREQ; go to LOAD. With no req, stay in IDLE and all outputs hold idle values.
- LOAD: one cycle. div_rst=1. div_in=op_reg. Go to RUN and clear cnt to 0.
- RUN: div_in=op_reg. div_rst=0. cnt increments each cycle.
  - If div_done=1: rsp_data_reg<=div_out; err<=0; go to RESP.
  - Else if cnt==TIMEOUT: rsp_data_reg<=0; err<=1; go to RESP.
  - div_done takes priority if both conditions hold in the same cycle.
- RESP: rsp_valid=1, rsp_id=id_reg, rsp_err=err; go to IDLE. No grant is issued in RESP.
- div_done is ignored outside RUN. It stays high from the previous job through LOAD, and that stale value must not end the new job.
- div_rst = rst OR (state==LOAD), decoded from registered state (glitch-free).
- A req that drops before it is granted is never granted. Unrequested bits are skipped by the round-robin search.
- Withdrawing req after gnt has no effect; the job completes.

## Timing
- Reset values: state=IDLE, ptr=0, gnt=0, busy=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, div_in=0, cnt=0. div_rst=1 while rst is high.
- Job cycle numbering, with gnt in cycle g:
  - g+1: LOAD.
  - g+2: divider latches its input.
  - g+3 .. g+2+N/32: divider computes.
  - g+3+N/32: divider registers done.
  - g+4+N/32: div_done visible; captured by the scheduler.
  - g+5+N/32: rsp_valid.
- For N=4480: rsp_valid at g+145; the next gnt is possible at g+146.
- Timeout path: RUN starts at g+2 with cnt=0, reaches cnt==TIMEOUT at g+2+TIMEOUT, and rsp_valid/rsp_err appear at g+3+TIMEOUT (g+151 for defaults).
- busy is high from g+1 through the RESP cycle inclusive.
- rst mid-job: on the next edge, state=IDLE, gnt=0, rsp_valid=0, and ptr=0. The in-flight job is dropped with no response. div_rst stays high for every rst cycle.

## Test plan
- Single job: req[2]=1 with operand 1 (x^0) → gnt[2] at g. Quotient is all-ones (prefix XOR, all N bits set) at g+145, with rsp_id=2 and rsp_err=0.
- Contention: req=4'b1111 held → grants in order 0,1,2,3, 146 cycles apart. Then req=4'b1010 → order 1 then 3.
- Stale done: back-to-back jobs → second job's rsp arrives at its own g+145, not at g+1 or g+2.
- Hang: stub divider with div_done tied 0 → rsp_valid and rsp_err=1 with rsp_data=0 at g+151; the next pending request is granted at g+152.
- Reset mid-RUN: assert rst at g+50 for 2 cycles → no rsp_valid for that job; div_rst=1 during both rst cycles; the next req[0] is granted first because ptr=0.
- Withdrawn request: req[1] pulsed for 1 cycle while busy → never granted; no rsp for id 1.
